// File: rtl/hack_pkg.sv
// hack_pkg: shared Hack CPU widths and fetch-unit state encodings.
//   HACK_ADDR_W / HACK_DATA_W : default PC and instruction widths
//   fetch_state_t             : instruction fetch FSM states (2 bits)
package hack_pkg;
  localparam int HACK_ADDR_W = 16;
  localparam int HACK_DATA_W = 16;

  typedef enum logic [1:0] {
    FS_IDLE     = 2'd0,
    FS_DEMAND   = 2'd1,
    FS_PREFETCH = 2'd2,
    FS_DRAIN    = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/instr_fetch_reg.sv
// instr_fetch_reg: generic loadable register with async active-low clear.
//   clk, reset_n : clock, async clear to zero
//   load, d      : q <= d on a rising edge while load=1
//   q            : stored word
module instr_fetch_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (load) q <= d;
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: Hack CPU instruction fetch with a two-entry tagged buffer
// (cur/nxt) and sequential prefetch over a req/ack memory port.
//   clk, reset_n          : clock, async active-low reset
//   pc_addr, fetch, flush : CPU side request / buffer invalidate pulse
//   instr, instr_valid    : word for pc_addr, combinational from buffer regs
//   mem_req, mem_addr     : registered memory request, address held until ack
//   mem_ack, mem_rdata    : one-cycle ack with data
module instr_fetch
  import hack_pkg::*;
#(
  parameter int ADDR_W      = HACK_ADDR_W,
  parameter int DATA_W      = HACK_DATA_W,
  parameter bit PREFETCH_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              fetch,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);
  fetch_state_t      state, state_d;
  logic              mem_req_d;
  logic [ADDR_W-1:0] mem_addr_d;

  logic              cur_v, nxt_v;
  logic [ADDR_W-1:0] cur_tag, nxt_tag;
  logic [DATA_W-1:0] cur_data, nxt_data, cur_d;

  logic              hit_cur, hit_nxt, promote;
  logic              fill_cur, fill_nxt;
  logic              eff_cur_v, eff_nxt_v;
  logic [ADDR_W-1:0] eff_cur_tag, pf_tag;
  logic              pf_need;

  // Data words live in plain load-enabled registers; tags/valids below.
  assign cur_d = fill_cur ? mem_rdata : nxt_data;

  instr_fetch_reg #(.W(DATA_W)) u_cur_data (
    .clk(clk), .reset_n(reset_n), .load(fill_cur | promote), .d(cur_d), .q(cur_data)
  );
  instr_fetch_reg #(.W(DATA_W)) u_nxt_data (
    .clk(clk), .reset_n(reset_n), .load(fill_nxt), .d(mem_rdata), .q(nxt_data)
  );

  always_comb begin
    hit_cur     = cur_v && (cur_tag == pc_addr);
    hit_nxt     = nxt_v && (nxt_tag == pc_addr);
    instr_valid = hit_cur | hit_nxt;
    instr       = '0;
    if (hit_cur)      instr = cur_data;
    else if (hit_nxt) instr = nxt_data;
    promote     = fetch & hit_nxt & ~hit_cur;

    // Prefetch looks at the buffer as it will be after this edge's
    // promotion, so the next sequential word is requested in the same
    // cycle nxt is consumed (keeps zero-wait code at 1 instr / 2 cycles).
    eff_cur_v   = cur_v | promote;
    eff_cur_tag = promote ? nxt_tag : cur_tag;
    eff_nxt_v   = nxt_v & ~promote;
    pf_tag      = eff_cur_tag + ADDR_W'(1);
    pf_need     = PREFETCH_EN && eff_cur_v && !(eff_nxt_v && (nxt_tag == pf_tag));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= FS_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= state_d;
      mem_req  <= mem_req_d;
      mem_addr <= mem_addr_d;
    end
  end

  // mem_addr doubles as req_tag: it is held for the whole transaction.
  always_comb begin
    state_d    = state;
    mem_req_d  = mem_req;
    mem_addr_d = mem_addr;
    fill_cur   = 1'b0;
    fill_nxt   = 1'b0;
    unique case (state)
      FS_IDLE: begin
        if (!flush) begin
          if (fetch && !instr_valid) begin
            state_d    = FS_DEMAND;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_addr;
          end else if (pf_need) begin
            state_d    = FS_PREFETCH;
            mem_req_d  = 1'b1;
            mem_addr_d = pf_tag;
          end
        end
      end
      FS_DEMAND, FS_PREFETCH: begin
        if (mem_ack) begin
          state_d   = FS_IDLE;
          mem_req_d = 1'b0;
          fill_cur  = !flush && (state == FS_DEMAND);
          fill_nxt  = !flush && (state == FS_PREFETCH);
        end else if (flush) begin
          state_d = FS_DRAIN;
        end
      end
      FS_DRAIN: begin
        if (mem_ack) begin
          state_d   = FS_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_v   <= 1'b0;
      nxt_v   <= 1'b0;
      cur_tag <= '0;
      nxt_tag <= '0;
    end else if (flush) begin
      cur_v <= 1'b0;
      nxt_v <= 1'b0;
    end else if (fill_cur) begin
      cur_tag <= mem_addr;
      cur_v   <= 1'b1;
      nxt_v   <= 1'b0;
    end else begin
      if (promote) begin
        cur_tag <= nxt_tag;
        cur_v   <= 1'b1;
      end
      // A prefetch fill landing on a promotion edge refills nxt.
      if (fill_nxt) begin
        nxt_tag <= mem_addr;
        nxt_v   <= 1'b1;
      end else if (promote) begin
        nxt_v <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] pc_addr = '0;
  logic        fetch = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(16), .DATA_W(16), .PREFETCH_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .pc_addr(pc_addr), .fetch(fetch), .flush(flush),
    .instr(instr), .instr_valid(instr_valid), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Memory model: ack after 'lat' extra cycles of mem_req; data = addr^A5A5
  // unless the override address matches.
  int          lat = 0;
  int          cnt = 0;
  logic        ov_en = 1'b0;
  logic [15:0] ov_addr = '0;
  logic [15:0] ov_data = '0;

  function automatic logic [15:0] rom(input logic [15:0] a);
    if (ov_en && a == ov_addr) return ov_data;
    return a ^ 16'hA5A5;
  endfunction

  always @(negedge clk or negedge reset_n) begin
    mem_ack <= 1'b0;
    if (!reset_n) cnt <= 0;
    else if (mem_req) begin
      if (cnt >= lat) begin
        mem_ack   <= 1'b1;
        mem_rdata <= rom(mem_addr);
        cnt       <= 0;
      end else cnt <= cnt + 1;
    end else cnt <= 0;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    fetch = 1'b0; flush = 1'b0; pc_addr = '0; reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk1("rst_in_req", mem_req, 1'b0);
    chk1("rst_in_valid", instr_valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk1("rst_req", mem_req, 1'b0);
    chk16("rst_addr", mem_addr, 16'h0000);
    chk1("rst_valid", instr_valid, 1'b0);
    chk16("rst_instr", instr, 16'h0000);
  endtask

  typedef struct {
    bit          rst;
    logic [15:0] pc;
    logic        exp_v;
    logic [15:0] exp_i;
    logic        exp_req;
    logic [15:0] exp_addr;
  } vec_t;
  vec_t tbl[14];

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (tbl[i].rst) do_reset();
      pc_addr = tbl[i].pc;
      fetch   = 1'b1;
      #1;
      chk1($sformatf("row%0d_valid", i), instr_valid, tbl[i].exp_v);
      if (tbl[i].exp_v) chk16($sformatf("row%0d_instr", i), instr, tbl[i].exp_i);
      chk1($sformatf("row%0d_req", i), mem_req, tbl[i].exp_req);
      if (tbl[i].exp_req) chk16($sformatf("row%0d_addr", i), mem_addr, tbl[i].exp_addr);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] p;
    logic        got;
    logic        saw_dead;
    int          cyc;
    int          n;

    // zero-wait sequential warm-up from reset (rows 0-7), wrap-around (8-13)
    tbl[0]  = '{1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 16'hA5A5, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 16'h0001, 1'b0, 16'h0000, 1'b1, 16'h0001};
    tbl[4]  = '{1'b0, 16'h0001, 1'b1, 16'hA5A4, 1'b0, 16'h0000};
    tbl[5]  = '{1'b0, 16'h0002, 1'b0, 16'h0000, 1'b1, 16'h0002};
    tbl[6]  = '{1'b0, 16'h0002, 1'b1, 16'hA5A7, 1'b0, 16'h0000};
    tbl[7]  = '{1'b0, 16'h0003, 1'b0, 16'h0000, 1'b1, 16'h0003};
    tbl[8]  = '{1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[9]  = '{1'b0, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 16'hFFFF};
    tbl[10] = '{1'b0, 16'hFFFF, 1'b1, 16'h5A5A, 1'b0, 16'h0000};
    tbl[11] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 16'hA5A5, 1'b0, 16'h0000};
    tbl[13] = '{1'b0, 16'h0001, 1'b0, 16'h0000, 1'b1, 16'h0001};

    // ---- cold miss, ack 3 cycles after req ----
    do_reset();
    lat = 3; ov_en = 1'b1; ov_addr = 16'h0000; ov_data = 16'h1234;
    pc_addr = 16'h0000; fetch = 1'b1;
    tick();
    #1;
    chk1("cold_req", mem_req, 1'b1);
    chk16("cold_addr", mem_addr, 16'h0000);
    for (int c = 2; c <= 4; c++) begin
      tick(); #1;
      chk1($sformatf("cold_c%0d_valid", c), instr_valid, 1'b0);
      chk1($sformatf("cold_c%0d_req", c), mem_req, 1'b1);
    end
    tick(); #1;
    chk1("cold_valid", instr_valid, 1'b1);
    chk16("cold_instr", instr, 16'h1234);
    chk1("cold_req_drop", mem_req, 1'b0);
    tick(); #1;
    chk1("cold_pf_req", mem_req, 1'b1);
    chk16("cold_pf_addr", mem_addr, 16'h0001);
    ov_en = 1'b0;

    // ---- sequential run, zero-wait ----
    lat = 0;
    run_rows(0, 7);
    p = 16'h0003; cyc = 8;
    pc_addr = p;
    while (cyc <= 34) begin
      #1;
      chk1($sformatf("seq_c%0d_valid", cyc), instr_valid, (cyc % 2) == 0);
      if (instr_valid) chk16($sformatf("seq_c%0d_instr", cyc), instr, p ^ 16'hA5A5);
      got = instr_valid;
      if (cyc == 34) break;
      tick();
      if (got) p = p + 16'h1;
      pc_addr = p;
      cyc++;
    end
    chk16("seq_last_instr", instr, 16'hA5B5);

    // ---- jump to 0x0200 while prefetch of 0x0011 is in flight ----
    lat = 4;
    tick();
    pc_addr = 16'h0200;
    for (int c = 35; c <= 39; c++) begin
      #1;
      chk1($sformatf("jmp_c%0d_req", c), mem_req, 1'b1);
      chk16($sformatf("jmp_c%0d_addr", c), mem_addr, 16'h0011);
      chk1($sformatf("jmp_c%0d_valid", c), instr_valid, 1'b0);
      tick();
    end
    #1;
    chk1("jmp_gap_req", mem_req, 1'b0);
    tick(); #1;
    chk1("jmp_dem_req", mem_req, 1'b1);
    chk16("jmp_dem_addr", mem_addr, 16'h0200);
    n = 0;
    while (!instr_valid && n < 12) begin
      tick(); #1;
      n++;
    end
    chk1("jmp_valid", instr_valid, 1'b1);
    chk16("jmp_instr", instr, 16'hA7A5);
    chk16("jmp_latency", 16'(n), 16'd5);
    pc_addr = 16'h0011;
    #1;
    chk1("jmp_nxt_cleared", instr_valid, 1'b0);
    pc_addr = 16'h0200;
    #1;

    // ---- wrap-around prefetch ----
    lat = 0;
    run_rows(8, 13);

    // ---- flush while DEMAND for 0x0040 waits ----
    do_reset();
    lat = 3; ov_en = 1'b1; ov_addr = 16'h0040; ov_data = 16'hDEAD;
    pc_addr = 16'h0040; fetch = 1'b1;
    tick(); #1;
    chk1("fl_req", mem_req, 1'b1);
    chk16("fl_addr", mem_addr, 16'h0040);
    tick();
    flush = 1'b1;
    #1;
    chk1("fl_c2_valid", instr_valid, 1'b0);
    tick();
    flush = 1'b0;
    #1;
    chk1("fl_drain_req", mem_req, 1'b1);
    chk1("fl_c3_valid", instr_valid, 1'b0);
    tick(); #1;
    chk1("fl_c4_valid", instr_valid, 1'b0);
    ov_data = 16'hBEEF;
    tick(); #1;
    chk1("fl_c5_valid", instr_valid, 1'b0);
    chk1("fl_c5_req", mem_req, 1'b0);
    tick(); #1;
    chk1("fl_refetch_req", mem_req, 1'b1);
    chk16("fl_refetch_addr", mem_addr, 16'h0040);
    n = 0; saw_dead = 1'b0;
    while (!instr_valid && n < 12) begin
      tick(); #1;
      n++;
    end
    chk1("fl_valid", instr_valid, 1'b1);
    chk16("fl_instr", instr, 16'hBEEF);

    // ---- flush coinciding with ack ----
    do_reset();
    lat = 2; ov_data = 16'hDEAD;
    pc_addr = 16'h0040; fetch = 1'b1;
    tick(); #1;
    chk1("fa_req", mem_req, 1'b1);
    tick();
    tick();
    flush = 1'b1;
    #1;
    chk1("fa_c3_valid", instr_valid, 1'b0);
    tick();
    flush = 1'b0; ov_data = 16'hBEEF;
    #1;
    chk1("fa_c4_valid", instr_valid, 1'b0);
    chk1("fa_c4_req", mem_req, 1'b0);
    tick(); #1;
    chk1("fa_refetch_req", mem_req, 1'b1);
    chk16("fa_refetch_addr", mem_addr, 16'h0040);
    n = 0;
    while (!instr_valid && n < 12) begin
      if (instr_valid && instr == 16'hDEAD) saw_dead = 1'b1;
      tick(); #1;
      n++;
    end
    chk1("fa_valid", instr_valid, 1'b1);
    chk16("fa_instr", instr, 16'hBEEF);
    chk1("fa_no_dead", saw_dead, 1'b0);
    ov_en = 1'b0;

    // ---- async reset with a request outstanding ----
    do_reset();
    lat = 5;
    pc_addr = 16'h0123; fetch = 1'b1;
    tick(); #1;
    chk1("ar_req", mem_req, 1'b1);
    chk16("ar_addr", mem_addr, 16'h0123);
    #2;
    reset_n = 1'b0;
    #1;
    chk1("ar_req_low", mem_req, 1'b0);
    chk1("ar_valid_low", instr_valid, 1'b0);
    chk16("ar_instr_zero", instr, 16'h0000);
    @(negedge clk);
    pc_addr = 16'h0077;
    reset_n = 1'b1;
    #1;
    chk1("ar_rel_req", mem_req, 1'b0);
    tick(); #1;
    chk1("ar_new_req", mem_req, 1'b1);
    chk16("ar_new_addr", mem_addr, 16'h0077);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the Hack CPU. It is the reader on the other end of the program-counter address path. It takes the PC value each cycle and returns the ROM word at that address. It fetches from an external, variable-latency instruction memory (SDRAM/BRAM bridge) over a req/ack handshake. It keeps a two-entry tagged buffer with sequential prefetch, so straight-line code runs without stalls once the buffer is primed.

## Interface

Parameters:
- ADDR_W, 16: width of PC and memory address.
- DATA_W, 16: instruction word width.
- PREFETCH_EN, 1: when 1, the block speculatively fetches cur_tag+1; when 0, it issues demand fetches only.

Ports:
- clk, in, 1: single clock. All logic runs on the rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- pc_addr, in, ADDR_W: current PC output.
- fetch, in, 1: CPU requests the instruction at pc_addr this cycle.
- flush, in, 1: invalidate the buffer (ROM reloaded). Single-cycle pulse.
- instr, out, DATA_W: instruction for pc_addr. Meaningful only when instr_valid=1.
- instr_valid, out, 1: instr matches pc_addr this cycle. While 0, the CPU holds the PC.
- mem_req, out, 1: memory request. Registered.
- mem_addr, out, ADDR_W: request address. Registered and stable while mem_req=1.
- mem_ack, in, 1: one-cycle pulse; mem_rdata is valid in the same cycle.
- mem_rdata, in, DATA_W: read data.

## Operation

Buffer:
- Two entries, cur and nxt. Each has a tag (ADDR_W bits), data (DATA_W bits) and a valid bit.
- hit_cur = cur_v & (cur_tag == pc_addr). hit_nxt = nxt_v & (nxt_tag == pc_addr). Both are combinational.
- instr_valid = hit_cur | hit_nxt. instr comes from the hitting entry; cur wins if both hit.
- Promotion: on a clock edge where fetch & hit_nxt & !hit_cur, cur <= nxt and nxt_v <= 0.

State machine (IDLE, DEMAND, PREFETCH, DRAIN):
- IDLE, miss: if fetch & !instr_valid, go to DEMAND. Next cycle mem_req=1 and mem_addr=pc_addr; the address is captured as req_tag.
- IDLE, prefetch: otherwise, if PREFETCH_EN & cur_v & !(nxt_v & nxt_tag == cur_tag+1), go to PREFETCH with req_tag = cur_tag+1.
- Increment wraps modulo 2^ADDR_W (0xFFFF -> 0x0000).
- IDLE, otherwise: stay; mem_req=0.
- DEMAND: on mem_ack, write cur = {req_tag, mem_rdata, 1}, clear nxt_v, go to IDLE.
- PREFETCH: on mem_ack, write nxt = {req_tag, mem_rdata, 1}, go to IDLE.
- A demand miss during PREFETCH waits for the ack. The demand is issued from IDLE afterwards, or the miss hits if it targeted req_tag.
- In-flight transactions are never aborted. mem_req drops the cycle after ack; the next request can assert one cycle later.
- Fills are written by tag regardless of the current pc_addr. A PC change mid-fetch (CPU reset, jump) causes at most a later miss, never wrong data.

Flush:
- Clears cur_v and nxt_v on the same edge.
- If a transaction is in flight without an ack that cycle, go to DRAIN. DRAIN waits for mem_ack, discards the data, then goes to IDLE.
- flush coinciding with mem_ack: flush wins, data is dropped, go to IDLE.

Reset:
- reset_n=0 asynchronously sets state=IDLE, mem_req=0, mem_addr=0, cur_v=nxt_v=0, all tags/data=0.
- instr_valid=0 and instr=0 during and after reset.
- A request abandoned by reset is the memory side's concern; the memory side shares reset_n.

## Timing

- Miss latency: miss seen in cycle 0; mem_req=1 in cycle 1; ack in cycle k≥1; instr_valid=1 in cycle k+1.
- Zero-wait memory (ack in the same cycle mem_req first rises): demand miss costs 2 stall cycles.
- Prefetch issue: from IDLE, the cycle after cur fills.
- With zero-wait memory, sequential code settles to one instruction every 2 cycles.
- Hits add zero cycles: instr_valid is combinational from registered entries.
- No combinational path from mem_ack/mem_rdata to instr/instr_valid. Data passes through the buffer registers.

## Structure

- Shared package/include hack_pkg:
  - HACK_ADDR_W, HACK_DATA_W.
  - Fetch state encodings FS_IDLE, FS_DEMAND, FS_PREFETCH, FS_DRAIN (2 bits).
- Sub-module: buffer entry storage reuses the existing Register block for data words, with load = fill enable.
  - The tag/valid bits and the FSM are local flops with async clear.
- Expected size: roughly 150–250 lines.

## Test plan

- **Cold miss:** after reset, fetch=1, pc_addr=0x0000, memory acks 3 cycles after req with rdata=0x1234.
  - Expect mem_addr=0x0000, then instr_valid=1 and instr=0x1234 exactly one cycle after ack.
  - Expect mem_req=1 for 0x0001 on the following cycle.
- **Sequential run:** zero-wait memory returning rdata = addr^0xA5A5, PC incrementing on instr_valid over 0x0000–0x0010.
  - Every delivered instr is correct.
  - After warm-up, instr_valid toggles in the 1-of-2 pattern with zero-wait memory.
- **Jump during prefetch:** prefetch of 0x0011 in flight, pc_addr jumps to 0x0200.
  - Expect no new req until ack.
  - Then DEMAND for 0x0200; nxt_v cleared; instr for 0x0200 correct.
- **Wrap-around:** cur_tag=0xFFFF with PREFETCH_EN=1.
  - Expect prefetch mem_addr=0x0000, and a hit at pc_addr=0x0000 with no demand request.
- **Flush mid-transaction:** flush pulsed while a DEMAND for 0x0040 awaits ack (rdata=0xDEAD).
  - Expect DRAIN, 0xDEAD never presented, and a fresh request for 0x0040 after ack.
  - Flush coinciding with ack: the data is also dropped.
- **Async reset mid-request:** reset_n low between clock edges with mem_req=1.
  - Expect mem_req=0 and instr_valid=0 immediately, without waiting for a clock edge.
  - After release, the first request goes out for the current pc_addr.
